hack_decoder_seq: RTL and testbench

Parametrised, registered one-hot decoder. Maps a SEL_W-bit select to a 2**SEL_W one-hot output using MSB-first ordering: value v drives out[OUT_W-1-v]. Adds a direct mode and an auto-scanning mode with per-step dwell, a one-shot option, a wrap pulse and an enable-freeze. Used for bank and row selection and for peripheral strobing in the Hack datapath; the existing 2-to-4 gate decoder remains for purely combinational sites.

---
 rtl/hack_decoder_seq_pkg.sv | 18 +
 rtl/hack_onehot.sv | 18 +
 rtl/hack_decoder_seq.sv | 142 ++++++++++++++
 tb/tb_hack_decoder_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_decoder_seq_pkg.sv
// Shared encodings for the Hack sequenced decoder: mode input values and FSM states.
package hack_decoder_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_DIRECT = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_ONCE   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DIRECT = 2'b01,
        ST_SCAN   = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/hack_onehot.sv
// Combinational MSB-first one-hot: index v lights onehot_o[2**SEL_W-1-v].
module hack_onehot #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      idx_i,
    output logic [(2**SEL_W)-1:0] onehot_o
);

    localparam int OUT_W = 2 ** SEL_W;

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot_o[OUT_W-1-i] = (idx_i == SEL_W'(i));
        end
    end

endmodule

// File: rtl/hack_decoder_seq.sv
// Registered one-hot decoder with direct, continuous-scan and one-shot scan modes.
// Every output is a flop; the next output value is derived from the next state/index.
module hack_decoder_seq
    import hack_decoder_seq_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  load,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] out,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] IDX_LAST = {SEL_W{1'b1}};

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               wrap_q, wrap_d;
    logic               busy_q, busy_d;
    logic [OUT_W-1:0]   onehot_next;
    mode_e              mode_s;

    assign mode_s = mode_e'(mode);

    hack_onehot #(.SEL_W(SEL_W)) u_onehot (
        .idx_i    (idx_d),
        .onehot_o (onehot_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
        end
    end

    // With en low everything holds and wrap_d stays 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    case (mode_s)
                        MODE_DIRECT: begin
                            state_d = ST_DIRECT;
                            idx_d   = sel;
                        end
                        MODE_SCAN, MODE_ONCE: begin
                            state_d = ST_SCAN;
                            idx_d   = sel;
                            cnt_d   = dwell;
                        end
                        default: ;
                    endcase
                end
                ST_DIRECT: begin
                    if (mode_s == MODE_OFF) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (load) idx_d = sel;
                        if (mode_s == MODE_SCAN || mode_s == MODE_ONCE) begin
                            state_d = ST_SCAN;
                            cnt_d   = dwell;
                        end
                    end
                end
                ST_SCAN: begin
                    if (mode_s == MODE_OFF) begin
                        state_d = ST_IDLE;
                    end else if (mode_s == MODE_DIRECT) begin
                        state_d = ST_DIRECT;
                    end else if (load) begin
                        idx_d = sel;
                        cnt_d = dwell;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else begin
                        // Step: dwell is sampled here, so mid-step dwell changes wait for the next position.
                        cnt_d = dwell;
                        if (idx_q == IDX_LAST) begin
                            wrap_d = 1'b1;
                            idx_d  = '0;
                            if (mode_s == MODE_ONCE) state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + SEL_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    case (mode_s)
                        MODE_OFF: state_d = ST_IDLE;
                        MODE_DIRECT: begin
                            state_d = ST_DIRECT;
                            idx_d   = sel;
                        end
                        default: ;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_d  = '0;
        busy_d = (state_d == ST_SCAN);
        if (state_d == ST_DIRECT || state_d == ST_SCAN) out_d = onehot_next;
    end

    assign out       = out_q;
    assign idx       = idx_q;
    assign wrap      = wrap_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_hack_decoder_seq.sv
// Directed bench for hack_decoder_seq (SEL_W=2, DWELL_W=8): vector table plus multi-cycle sequences.
module tb_hack_decoder_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [1:0] sel;
    logic       load;
    logic [7:0] dwell;
    logic [3:0] out;
    logic [1:0] idx;
    logic       wrap;
    logic       busy;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [1:0] sel;
        logic       load;
        logic [7:0] dwell;
        logic [3:0] exp_out;
        logic [1:0] exp_idx;
        logic       exp_wrap;
        logic       exp_busy;
    } vec_t;

    vec_t       vq[$];
    logic [3:0] exp_q[$];

    hack_decoder_seq #(.SEL_W(2), .DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .load      (load),
        .dwell     (dwell),
        .out       (out),
        .idx       (idx),
        .wrap      (wrap),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_o(input string tag, input logic [3:0] eo, input logic [1:0] ei,
                            input logic ew, input logic eb);
        chk({tag, ".out"},  32'(out),  32'(eo));
        chk({tag, ".idx"},  32'(idx),  32'(ei));
        chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
    endtask

    task automatic add(input logic e, input logic [1:0] m, input logic [1:0] s, input logic l,
                       input logic [3:0] eo, input logic [1:0] ei, input logic ew, input logic eb);
        vq.push_back('{e, m, s, l, 8'd0, eo, ei, ew, eb});
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'b00;
        sel   = 2'b00;
        load  = 1'b0;
        dwell = 8'd0;

        // Power-on reset
        #12;
        expect_o("por", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("por.state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_o("por_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Legacy DIRECT truth table, hold, freeze, then continuous scan with dwell=0
        add(1, 2'b01, 2'b00, 0, 4'b1000, 2'd0, 0, 0);
        add(1, 2'b01, 2'b01, 1, 4'b0100, 2'd1, 0, 0);
        add(1, 2'b01, 2'b10, 1, 4'b0010, 2'd2, 0, 0);
        add(1, 2'b01, 2'b11, 1, 4'b0001, 2'd3, 0, 0);
        add(1, 2'b01, 2'b00, 0, 4'b0001, 2'd3, 0, 0);
        add(1, 2'b01, 2'b01, 0, 4'b0001, 2'd3, 0, 0);
        add(1, 2'b00, 2'b00, 0, 4'b0000, 2'd3, 0, 0);
        add(1, 2'b00, 2'b10, 0, 4'b0000, 2'd3, 0, 0);
        add(1, 2'b10, 2'b00, 0, 4'b1000, 2'd0, 0, 1);
        add(1, 2'b10, 2'b11, 0, 4'b0100, 2'd1, 0, 1);
        add(1, 2'b10, 2'b11, 0, 4'b0010, 2'd2, 0, 1);
        add(1, 2'b10, 2'b11, 0, 4'b0001, 2'd3, 0, 1);
        add(1, 2'b10, 2'b11, 0, 4'b1000, 2'd0, 1, 1);
        add(1, 2'b10, 2'b11, 0, 4'b0100, 2'd1, 0, 1);
        add(1, 2'b10, 2'b11, 0, 4'b0010, 2'd2, 0, 1);
        add(1, 2'b10, 2'b11, 0, 4'b0001, 2'd3, 0, 1);
        add(1, 2'b10, 2'b11, 0, 4'b1000, 2'd0, 1, 1);
        add(1, 2'b01, 2'b11, 0, 4'b1000, 2'd0, 0, 0);
        add(0, 2'b01, 2'b11, 1, 4'b1000, 2'd0, 0, 0);
        add(1, 2'b00, 2'b11, 0, 4'b0000, 2'd0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            en    = vq[i].en;
            mode  = vq[i].mode;
            sel   = vq[i].sel;
            load  = vq[i].load;
            dwell = vq[i].dwell;
            exp_q.push_back(vq[i].exp_out);
            tick();
            chk($sformatf("vec%0d.out", i), 32'(out), 32'(exp_q.pop_front()));
            chk($sformatf("vec%0d.idx", i), 32'(idx), 32'(vq[i].exp_idx));
            chk($sformatf("vec%0d.wrap", i), 32'(wrap), 32'(vq[i].exp_wrap));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vq[i].exp_busy));
        end
        en   = 1'b1;
        load = 1'b0;

        // Dwell=2 with a 5-cycle freeze mid-position, then a dwell change mid-step
        mode = 2'b10; sel = 2'b01; dwell = 8'd2;
        tick(); expect_o("dw.e0", 4'b0100, 2'd1, 1'b0, 1'b1);
        tick(); expect_o("dw.e1", 4'b0100, 2'd1, 1'b0, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); expect_o($sformatf("frz%0d", i), 4'b0100, 2'd1, 1'b0, 1'b1);
        end
        en = 1'b1;
        tick(); expect_o("dw.e2", 4'b0100, 2'd1, 1'b0, 1'b1);
        tick(); expect_o("dw.e3", 4'b0010, 2'd2, 1'b0, 1'b1);
        dwell = 8'd5;
        tick(); expect_o("dw.e4", 4'b0010, 2'd2, 1'b0, 1'b1);
        tick(); expect_o("dw.e5", 4'b0010, 2'd2, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(); expect_o($sformatf("dw5.%0d", i), 4'b0001, 2'd3, 1'b0, 1'b1);
        end
        tick(); expect_o("dw.wrap", 4'b1000, 2'd0, 1'b1, 1'b1);

        // One-shot pass from index 2 with dwell=1
        mode = 2'b00;
        tick(); expect_o("os.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        mode = 2'b11; sel = 2'b10; dwell = 8'd1;
        tick(); expect_o("os.a0", 4'b0010, 2'd2, 1'b0, 1'b1);
        tick(); expect_o("os.a1", 4'b0010, 2'd2, 1'b0, 1'b1);
        tick(); expect_o("os.b0", 4'b0001, 2'd3, 1'b0, 1'b1);
        tick(); expect_o("os.b1", 4'b0001, 2'd3, 1'b0, 1'b1);
        tick(); expect_o("os.end", 4'b0000, 2'd0, 1'b1, 1'b0);
        chk("os.state", 32'(state_dbg), 32'd3);
        tick(); expect_o("os.hold0", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(); expect_o("os.hold1", 4'b0000, 2'd0, 1'b0, 1'b0);
        mode = 2'b00;
        tick(); expect_o("os.off", 4'b0000, 2'd0, 1'b0, 1'b0);
        mode = 2'b11;
        tick(); expect_o("os.re0", 4'b0010, 2'd2, 1'b0, 1'b1);
        tick(); expect_o("os.re1", 4'b0010, 2'd2, 1'b0, 1'b1);
        tick(); expect_o("os.re2", 4'b0001, 2'd3, 1'b0, 1'b1);
        tick(); expect_o("os.re3", 4'b0001, 2'd3, 1'b0, 1'b1);
        tick(); expect_o("os.re_end", 4'b0000, 2'd0, 1'b1, 1'b0);
        mode = 2'b01; sel = 2'b01;
        tick(); expect_o("os.to_dir", 4'b0100, 2'd1, 1'b0, 1'b0);

        // Load beats a wrapping step; mode=00 beats a wrapping step
        mode = 2'b00;
        tick(); expect_o("pr.idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        mode = 2'b10; sel = 2'b11; dwell = 8'd0;
        tick(); expect_o("pr.e0", 4'b0001, 2'd3, 1'b0, 1'b1);
        load = 1'b1; dwell = 8'd1;
        tick(); expect_o("pr.load", 4'b0001, 2'd3, 1'b0, 1'b1);
        load = 1'b0; dwell = 8'd0;
        tick(); expect_o("pr.cnt", 4'b0001, 2'd3, 1'b0, 1'b1);
        tick(); expect_o("pr.wrap", 4'b1000, 2'd0, 1'b1, 1'b1);
        tick(); expect_o("pr.s1", 4'b0100, 2'd1, 1'b0, 1'b1);
        tick(); expect_o("pr.s2", 4'b0010, 2'd2, 1'b0, 1'b1);
        tick(); expect_o("pr.s3", 4'b0001, 2'd3, 1'b0, 1'b1);
        mode = 2'b00;
        tick(); expect_o("pr.off", 4'b0000, 2'd3, 1'b0, 1'b0);

        // Asynchronous reset between edges during a scan
        mode = 2'b10; sel = 2'b10; dwell = 8'd3;
        tick(); expect_o("rs.scan", 4'b0010, 2'd2, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        mode  = 2'b00;
        #1;
        expect_o("rs.async", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("rs.state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); expect_o("rs.rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
